// File: rtl/logic_unit_pkg.sv
// Shared types for the round-robin arbitrated bitwise logic unit.
package logic_unit_pkg;

   typedef enum logic [1:0] {
      OP_AND  = 2'd0,
      OP_OR   = 2'd1,
      OP_XOR  = 2'd2,
      OP_NAND = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/logic_unit.sv
// Combinational 2-operand bitwise unit shared by all requesters.
module logic_unit
   import logic_unit_pkg::*;
#(
   parameter int unsigned W = 4
) (
   input  op_e            op,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [W-1:0]   y
);

   always_comb begin
      y = '0;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NAND: y = ~(a & b);
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic unit between N requesters;
// three-state sequencer returns one registered, ID-tagged result per operation.
module logic_unit_arbiter
   import logic_unit_pkg::*;
#(
   parameter  int unsigned N   = 4,
   parameter  int unsigned W   = 4,
   localparam int unsigned IDW = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req_valid,
   input  logic [2*N-1:0]   req_op,
   input  logic [W*N-1:0]   req_a,
   input  logic [W*N-1:0]   req_b,
   output logic [N-1:0]     req_ready,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [W-1:0]     rsp_data,
   output logic [IDW-1:0]   rsp_id,
   output logic             busy
);

   state_e           state_q, state_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   op_e              op_q, op_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic [IDW-1:0]   id_q, id_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [W-1:0]     rsp_data_q, rsp_data_d;
   logic [IDW-1:0]   rsp_id_q, rsp_id_d;
   logic             busy_q, busy_d;

   logic             found;
   logic [IDW-1:0]   win;
   logic [1:0]       win_op;
   logic [W-1:0]     win_a;
   logic [W-1:0]     win_b;
   logic [W-1:0]     unit_y;

   // Priority search starting at ptr, wrapping modulo N.
   always_comb begin
      int unsigned    idx;
      logic [IDW-1:0] idx_w;
      found = 1'b0;
      win   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         idx   = (32'(ptr_q) + k) % N;
         idx_w = IDW'(idx);
         if (!found && req_valid[idx_w]) begin
            found = 1'b1;
            win   = idx_w;
         end
      end
   end

   // Winner payload mux and one-hot accept strobe.
   always_comb begin
      win_op    = '0;
      win_a     = '0;
      win_b     = '0;
      req_ready = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (win == IDW'(i)) begin
            win_op = req_op[2*i +: 2];
            win_a  = req_a[W*i +: W];
            win_b  = req_b[W*i +: W];
            req_ready[i] = !rst && (state_q == S_IDLE) && found;
         end
      end
   end

   logic_unit #(.W(W)) u_unit (
      .op (op_q),
      .a  (a_q),
      .b  (b_q),
      .y  (unit_y)
   );

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      id_d        = id_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_id_d    = rsp_id_q;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               state_d = S_EXEC;
               op_d    = op_e'(win_op);
               a_d     = win_a;
               b_d     = win_b;
               id_d    = win;
               ptr_d   = (win == IDW'(N-1)) ? '0 : win + IDW'(1);
            end
         end
         S_EXEC: begin
            state_d     = S_RESP;
            rsp_data_d  = unit_y;
            rsp_id_d    = id_q;
            rsp_valid_d = 1'b1;
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         op_q        <= OP_AND;
         a_q         <= '0;
         b_q         <= '0;
         id_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         id_q        <= id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_id_q    <= rsp_id_d;
         busy_q      <= busy_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: request-level reference model plus response monitor.
module tb_logic_unit_arbiter;

   localparam int N   = 4;
   localparam int W   = 4;
   localparam int IDW = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req_valid;
   logic [2*N-1:0]   req_op;
   logic [W*N-1:0]   req_a;
   logic [W*N-1:0]   req_b;
   logic [N-1:0]     req_ready;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [W-1:0]     rsp_data;
   logic [IDW-1:0]   rsp_id;
   logic             busy;

   logic_unit_arbiter #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic [W-1:0] d;
      int           id;
      int           acc;
   } exp_t;
   exp_t sbq[$];

   // Requester-side model: pending requests, their payloads, rotation pointer.
   bit           pend [N];
   int           mop  [N];
   logic [W-1:0] ma   [N];
   logic [W-1:0] mb   [N];
   int           ptr_m;
   bit           free_m;
   int           rr_mode;   // 0 random, 1 always ready, 2 stalled

   function automatic void chk(string nm, int act, int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic logic [W-1:0] ref_op(int op, logic [W-1:0] a, logic [W-1:0] b);
      case (op)
         0:       return a & b;
         1:       return a | b;
         2:       return a ^ b;
         default: return ~(a & b);
      endcase
   endfunction

   task automatic set_req(int i, int op, logic [W-1:0] a, logic [W-1:0] b);
      pend[i] = 1'b1;
      mop[i]  = op;
      ma[i]   = a;
      mb[i]   = b;
   endtask

   // One clock: drive inputs after the edge, check accept/busy at the falling edge.
   task automatic step(input bit gen);
      int           w;
      logic [N-1:0] exp_rdy;
      @(posedge clk);
      #1;
      if (gen) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0)
               set_req(i, int'($urandom_range(0, 3)), W'($urandom), W'($urandom));
         end
      end
      for (int i = 0; i < N; i++) begin
         req_valid[i]       = pend[i];
         req_op[2*i +: 2]   = 2'(mop[i]);
         req_a[W*i +: W]    = ma[i];
         req_b[W*i +: W]    = mb[i];
      end
      rsp_ready = (rr_mode == 0) ? 1'($urandom_range(0, 1)) : (rr_mode == 1);
      @(negedge clk);
      exp_rdy = '0;
      w = -1;
      if (free_m) begin
         for (int k = 0; k < N; k++) begin
            if (w < 0 && pend[(ptr_m + k) % N]) w = (ptr_m + k) % N;
         end
         if (w >= 0) exp_rdy[w] = 1'b1;
      end
      chk("req_ready", int'(req_ready), int'(exp_rdy));
      chk("busy", int'(busy), int'(!free_m));
      if (w >= 0) begin
         sbq.push_back('{d: ref_op(mop[w], ma[w], mb[w]), id: w, acc: cyc});
         pend[w] = 1'b0;
         ptr_m   = (w + 1) % N;
         free_m  = 1'b0;
      end else if (!free_m && rsp_valid && rsp_ready) begin
         free_m = 1'b1;
      end
   endtask

   // Response monitor: latency, stability under stall, payload on handshake.
   bit           prev_v = 1'b0;
   logic [W-1:0] hold_d;
   logic [IDW-1:0] hold_id;
   always @(negedge clk) begin
      if (rst) begin
         prev_v = 1'b0;
      end else begin
         if (rsp_valid && !prev_v) begin
            if (sbq.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0 (cycle %0d)", cyc);
            end else begin
               chk("rsp_latency", cyc, sbq[0].acc + 2);
            end
            hold_d  = rsp_data;
            hold_id = rsp_id;
         end else if (rsp_valid && prev_v) begin
            chk("stall_data", int'(rsp_data), int'(hold_d));
            chk("stall_id", int'(rsp_id), int'(hold_id));
         end
         if (rsp_valid && rsp_ready && sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("rsp_data", int'(rsp_data), int'(e.d));
            chk("rsp_id", int'(rsp_id), e.id);
         end else if (!rsp_valid && sbq.size() > 0 && cyc > sbq[0].acc + 2) begin
            void'(sbq.pop_front());
            chk("rsp_timeout", 0, 1);
         end
         prev_v = rsp_valid;
      end
   end

   initial begin
      rst = 1'b1;
      req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < N; i++) begin
         pend[i] = 1'b0; mop[i] = 0; ma[i] = '0; mb[i] = '0;
      end
      ptr_m = 0; free_m = 1'b1; rr_mode = 1;

      repeat (2) @(negedge clk);
      req_valid = '1;
      #1;
      chk("rst_req_ready", int'(req_ready), 0);
      chk("rst_rsp_valid", int'(rsp_valid), 0);
      chk("rst_rsp_data", int'(rsp_data), 0);
      chk("rst_rsp_id", int'(rsp_id), 0);
      chk("rst_busy", int'(busy), 0);
      req_valid = '0;
      @(negedge clk);
      rst = 1'b0;

      // Single AND request on requester 0, then pointer must favour 1 over 0.
      set_req(0, 0, 4'b1100, 4'b1010);
      repeat (5) step(0);
      set_req(0, 1, 4'b0001, 4'b0010);
      set_req(1, 2, 4'b1111, 4'b0101);
      repeat (8) step(0);

      // All four opcodes on requester 2.
      for (int op = 0; op < 4; op++) begin
         set_req(2, op, 4'b0110, 4'b0011);
         repeat (4) step(0);
      end

      // Fairness: every requester kept valid.
      for (int t = 0; t < 26; t++) begin
         for (int i = 0; i < N; i++)
            if (!pend[i]) set_req(i, int'($urandom_range(0, 3)), W'($urandom), W'($urandom));
         step(0);
      end
      repeat (15) step(0);

      // Backpressure with a waiting request.
      rr_mode = 2;
      set_req(1, 2, 4'b1001, 4'b0011);
      repeat (3) step(0);
      set_req(3, 3, 4'b1010, 4'b1000);
      repeat (5) step(0);
      rr_mode = 1;
      repeat (6) step(0);

      // Operand change on the requester just accepted.
      set_req(2, 2, 4'b0101, 4'b0011);
      step(0);
      ma[2] = 4'b1111;
      mb[2] = 4'b0000;
      repeat (4) step(0);

      // Randomized traffic with random backpressure.
      rr_mode = 0;
      repeat (600) step(1);
      rr_mode = 1;
      repeat (40) step(0);

      // Reset asserted while an operation is in EXEC.
      set_req(0, 1, 4'b1111, 4'b0000);
      repeat (4) step(0);
      while (!free_m) step(0);
      set_req(1, 0, 4'b1111, 4'b1111);
      step(0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      sbq.delete();
      #1;
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_rsp_valid", int'(rsp_valid), 0);
      chk("mid_rst_rsp_data", int'(rsp_data), 0);
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      ptr_m = 0; free_m = 1'b1;
      req_valid = '0;
      @(negedge clk);
      rst = 1'b0;
      repeat (6) step(0);
      for (int i = 0; i < N; i++) set_req(i, i, 4'b0110, 4'b1100);
      repeat (16) step(0);

      repeat (5) step(0);
      if (sbq.size() != 0) chk("drain_outstanding", sbq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
